// File: rtl/ro_pair_evaluator.sv
// ----------------------------------------------------------------------------
// ro_pair_evaluator
//
// Measurement controller for the RO PUF. For each ring-oscillator pair
// selected from the challenge it clears the edge counters, lets both
// oscillators run for a fixed window, waits for the counters to settle and
// then compares Count_A against Count_B. RESP_BITS comparisons are packed
// into Response and handed off on a valid/ready handshake.
//
// Optional feature (macro RO_MARGIN_EN): adds parameter MARGIN and output
// Unstable, flagging comparisons whose count difference is below MARGIN.
//
// Ports:
//   Clock       in   system clock
//   Reset       in   asynchronous, active-high reset
//   Start       in   single-cycle request, sampled only in IDLE
//   Challenge   in   [SEL_W]     starting pair index, latched on Start
//   Count_A     in   [CNT_W]     counter of RO A of the selected pair
//   Count_B     in   [CNT_W]     counter of RO B of the selected pair
//   Pair_Sel    out  [SEL_W]     RO pair mux select
//   Cnt_Clear   out              counter clear
//   Ro_Enable   out              oscillator enable
//   Busy        out              high in every state except IDLE
//   Resp_Valid  out              Response valid
//   Resp_Ready  in               consumer accepts Response
//   Response    out  [RESP_BITS] comparison bits, bit i = comparison i
//   Tie         out              sticky: some comparison had Count_A == Count_B
//   Unstable    out  [RESP_BITS] (RO_MARGIN_EN only) |A-B| < MARGIN per bit
// ----------------------------------------------------------------------------
module ro_pair_evaluator #(
    parameter int CNT_W         = 32,
    parameter int SEL_W         = 4,
    parameter int RESP_BITS     = 8,
    parameter int WINDOW        = 1024,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
`ifdef RO_MARGIN_EN
    ,
    parameter int MARGIN        = 16
`endif
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     Challenge,
    input  logic [CNT_W-1:0]     Count_A,
    input  logic [CNT_W-1:0]     Count_B,
    output logic [SEL_W-1:0]     Pair_Sel,
    output logic                 Cnt_Clear,
    output logic                 Ro_Enable,
    output logic                 Busy,
    output logic                 Resp_Valid,
    input  logic                 Resp_Ready,
    output logic [RESP_BITS-1:0] Response,
`ifdef RO_MARGIN_EN
    output logic [RESP_BITS-1:0] Unstable,
`endif
    output logic                 Tie
);

    localparam int MAX_A   = (WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TW-1:0]    CLR_LAST = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0]    WIN_LAST = TW'(WINDOW - 1);
    localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          timer_q;
    logic [IDX_W-1:0]       index_q;
    logic [SEL_W-1:0]       pair_sel_q;
    logic                   cnt_clear_q;
    logic                   ro_enable_q;
    logic                   busy_q;
    logic                   resp_valid_q;
    logic [RESP_BITS-1:0]   response_q;
    logic                   tie_q;

    // Unsigned comparison over the full counter width.
    logic a_gt_b_d;
    logic a_eq_b_d;
    assign a_gt_b_d = (Count_A > Count_B);
    assign a_eq_b_d = (Count_A == Count_B);

`ifdef RO_MARGIN_EN
    logic [RESP_BITS-1:0] unstable_q;
    logic [CNT_W:0]       diff_d;
    logic                 unstable_d;

    // Magnitude of the difference, one bit wider so it can never wrap.
    assign diff_d     = a_gt_b_d ? ({1'b0, Count_A} - {1'b0, Count_B})
                                 : ({1'b0, Count_B} - {1'b0, Count_A});
    assign unstable_d = a_eq_b_d || (diff_d < (CNT_W+1)'(MARGIN));
    assign Unstable   = unstable_q;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            index_q      <= '0;
            pair_sel_q   <= '0;
            cnt_clear_q  <= 1'b0;
            ro_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            response_q   <= '0;
            tie_q        <= 1'b0;
`ifdef RO_MARGIN_EN
            unstable_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_q     <= S_CLEAR;
                        timer_q     <= '0;
                        index_q     <= '0;
                        pair_sel_q  <= Challenge;
                        response_q  <= '0;
                        tie_q       <= 1'b0;
                        cnt_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
`ifdef RO_MARGIN_EN
                        unstable_q  <= '0;
`endif
                    end
                end

                S_CLEAR: begin
                    if (timer_q == CLR_LAST) begin
                        timer_q     <= '0;
                        cnt_clear_q <= 1'b0;
                        ro_enable_q <= 1'b1;
                        state_q     <= S_RUN;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_RUN: begin
                    if (timer_q == WIN_LAST) begin
                        timer_q     <= '0;
                        ro_enable_q <= 1'b0;
                        state_q     <= S_SETTLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (timer_q == SET_LAST) begin
                        timer_q <= '0;
                        state_q <= S_COMPARE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_COMPARE: begin
                    response_q[index_q] <= a_gt_b_d;
                    if (a_eq_b_d) begin
                        tie_q <= 1'b1;
                    end
`ifdef RO_MARGIN_EN
                    unstable_q[index_q] <= unstable_d;
`endif
                    if (index_q == IDX_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        // Pair_Sel always equals base + index, so stepping it
                        // by one gives the modulo-2^SEL_W wrap for free.
                        index_q     <= index_q + 1'b1;
                        pair_sel_q  <= pair_sel_q + 1'b1;
                        cnt_clear_q <= 1'b1;
                        state_q     <= S_CLEAR;
                    end
                end

                S_DONE: begin
                    // Valid rises one cycle after the last bit is written so
                    // Response is already stable when it is presented.
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (Resp_Ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Pair_Sel   = pair_sel_q;
    assign Cnt_Clear  = cnt_clear_q;
    assign Ro_Enable  = ro_enable_q;
    assign Busy       = busy_q;
    assign Resp_Valid = resp_valid_q;
    assign Response   = response_q;
    assign Tie        = tie_q;

endmodule

// File: tb/tb_ro_pair_evaluator.sv
// ----------------------------------------------------------------------------
// tb_ro_pair_evaluator
//
// Self-checking bench for ro_pair_evaluator (WINDOW=16, CLR_CYCLES=2,
// SETTLE_CYCLES=4, i.e. 23 cycles per comparison). A small counter model
// returns Count_A/Count_B per Pair_Sel. Each run pushes its expected
// Response/Tie into a queue; a monitor pops and compares on every accepted
// handshake. Directed checks cover reset, latency, Pair_Sel wrap, pulse
// widths, tie, backpressure and reset abort. With RO_MARGIN_EN defined the
// Unstable output is also checked.
// ----------------------------------------------------------------------------
module tb_ro_pair_evaluator;

    localparam int CNT_W = 32;
    localparam int SEL_W = 4;
    localparam int RB    = 8;
    localparam int WIN   = 16;
    localparam int CLR   = 2;
    localparam int SET   = 4;
    localparam int PER   = CLR + WIN + SET + 1;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             Start;
    logic [SEL_W-1:0] Challenge;
    logic [CNT_W-1:0] Count_A;
    logic [CNT_W-1:0] Count_B;
    logic [SEL_W-1:0] Pair_Sel;
    logic             Cnt_Clear;
    logic             Ro_Enable;
    logic             Busy;
    logic             Resp_Valid;
    logic             Resp_Ready;
    logic [RB-1:0]    Response;
    logic             Tie;
`ifdef RO_MARGIN_EN
    logic [RB-1:0]    Unstable;
`endif

    always #5 Clock = ~Clock;

    // Counter model: the selected pair's counts.
    logic [CNT_W-1:0] cnt_a [16];
    logic [CNT_W-1:0] cnt_b [16];
    assign Count_A = cnt_a[Pair_Sel];
    assign Count_B = cnt_b[Pair_Sel];

    ro_pair_evaluator #(
        .CNT_W(CNT_W), .SEL_W(SEL_W), .RESP_BITS(RB),
        .WINDOW(WIN), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET)
`ifdef RO_MARGIN_EN
        , .MARGIN(16)
`endif
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Challenge(Challenge),
        .Count_A(Count_A), .Count_B(Count_B), .Pair_Sel(Pair_Sel),
        .Cnt_Clear(Cnt_Clear), .Ro_Enable(Ro_Enable), .Busy(Busy),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Response(Response),
`ifdef RO_MARGIN_EN
        .Unstable(Unstable),
`endif
        .Tie(Tie)
    );

    typedef struct packed {
        logic [RB-1:0] resp;
        logic          tie;
        logic [RB-1:0] unst;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_default();
        for (int i = 0; i < 16; i++) begin
            cnt_a[i] = (i % 2 == 0) ? 32'd200 : 32'd100;
            cnt_b[i] = (i % 2 == 0) ? 32'd100 : 32'd200;
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that samples Start.
    task automatic start_run(input logic [SEL_W-1:0] ch);
        @(negedge Clock);
        Challenge = ch;
        Start     = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (Resp_Valid !== 1'b1 && n < max) begin
            step();
            n++;
        end
        if (Resp_Valid !== 1'b1) chk("valid_timeout", 0, 1);
    endtask

    // Scoreboard monitor: samples mid-cycle, after the negedge drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            #2;
            if (Resp_Valid === 1'b1 && Resp_Ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_response", Response, e.resp);
                    chk("sb_tie", Tie, e.tie);
`ifdef RO_MARGIN_EN
                    chk("sb_unstable", Unstable, e.unst);
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int k;
        logic [RB-1:0] held;

        Reset = 1'b1; Start = 1'b0; Challenge = '0; Resp_Ready = 1'b1;
        set_default();
        repeat (3) step();
        chk("rst_pair_sel", Pair_Sel, 0);
        chk("rst_cnt_clear", Cnt_Clear, 0);
        chk("rst_ro_enable", Ro_Enable, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_valid", Resp_Valid, 0);
        chk("rst_response", Response, 0);
        chk("rst_tie", Tie, 0);
        @(negedge Clock);
        Reset = 1'b0;
        step();
        chk("idle_busy", Busy, 0);

        // Basic comparison and latency.
        exp_q.push_back('{resp: 8'h55, tie: 1'b0, unst: 8'h00});
        start_run(4'd0);
        chk("start_busy", Busy, 1);
        chk("start_clear", Cnt_Clear, 1);
        wait_valid(300, n);
        chk("latency", n, 1 + RB * PER);
        chk("done_busy", Busy, 1);
        step();
        chk("post_hs_valid", Resp_Valid, 0);
        chk("post_hs_busy", Busy, 0);
        chk("post_hs_resp_hold", Response, 8'h55);

        // Pair_Sel wrap and per-pair pulse widths.
        exp_q.push_back('{resp: 8'h55, tie: 1'b0, unst: 8'h00});
        start_run(4'd14);
        for (int p = 0; p < RB; p++) begin
            k = 0;
            while (Cnt_Clear !== 1'b1 && k < 50) begin step(); k++; end
            chk("wrap_pair_sel", Pair_Sel, (14 + p) % 16);
            n = 0;
            while (Cnt_Clear === 1'b1 && n < 50) begin n++; step(); end
            chk("wrap_clear_width", n, CLR);
            chk("wrap_no_overlap", Ro_Enable, 1);
            m = 0;
            while (Ro_Enable === 1'b1 && m < 50) begin m++; step(); end
            chk("wrap_enable_width", m, WIN);
        end
        wait_valid(100, n);
        step();
        step();

        // Tie at index 2; Tie stays set through DONE and after handshake.
        cnt_a[2] = 32'd77;
        cnt_b[2] = 32'd77;
        exp_q.push_back('{resp: 8'h51, tie: 1'b1, unst: 8'h04});
        start_run(4'd0);
        wait_valid(300, n);
        chk("tie_in_done", Tie, 1);
        chk("tie_resp", Response, 8'h51);
        step();
        chk("tie_after_hs", Tie, 1);
        set_default();

        // Next Start clears Tie; then hold off the handshake.
        exp_q.push_back('{resp: 8'h55, tie: 1'b0, unst: 8'h00});
        Resp_Ready = 1'b0;
        start_run(4'd0);
        chk("restart_tie_clr", Tie, 0);
        chk("restart_resp_clr", Response, 0);
        wait_valid(300, n);
        held = Response;
        chk("bp_resp", held, 8'h55);
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                @(negedge Clock);
                Start = 1'b1;
                step();
                Start = 1'b0;
            end else begin
                step();
            end
            chk("bp_valid_hold", Resp_Valid, 1);
            chk("bp_resp_hold", Response, held);
        end
        chk("bp_start_ignored_clear", Cnt_Clear, 0);
        @(negedge Clock);
        Resp_Ready = 1'b1;
        Start      = 1'b1;
        step();
        Start = 1'b0;
        chk("bp_valid_fall", Resp_Valid, 0);
        chk("bp_busy_fall", Busy, 0);
        step();
        chk("hs_start_ignored", Busy, 0);

        // Reset in the middle of RUN (cycle 100, pair 7 of a Challenge=3 run).
        start_run(4'd3);
        repeat (99) step();
        chk("pre_rst_enable", Ro_Enable, 1);
        chk("pre_rst_pair", Pair_Sel, 7);
        chk("pre_rst_resp", Response, 8'h0A);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_enable", Ro_Enable, 0);
        chk("async_rst_busy", Busy, 0);
        chk("async_rst_pair", Pair_Sel, 0);
        chk("async_rst_resp", Response, 0);
        chk("async_rst_clear", Cnt_Clear, 0);
        chk("async_rst_valid", Resp_Valid, 0);
        repeat (2) step();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) step();
        chk("post_rst_busy", Busy, 0);
        chk("post_rst_clear", Cnt_Clear, 0);
        chk("post_rst_enable", Ro_Enable, 0);

`ifdef RO_MARGIN_EN
        // Margin: pair 0 diff 10 (unstable), pair 1 diff 30 (stable).
        cnt_a[0] = 32'd110; cnt_b[0] = 32'd100;
        cnt_a[1] = 32'd130; cnt_b[1] = 32'd100;
        exp_q.push_back('{resp: 8'h57, tie: 1'b0, unst: 8'h01});
        start_run(4'd0);
        wait_valid(300, n);
        chk("margin_unstable", Unstable, 8'h01);
        step();
        set_default();
`endif

        step();
        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
